// File: rtl/rtc_bus_scheduler.sv
// Arbitrates three RTC register requesters onto one bus transaction engine.
// Fixed-priority requester 0, round-robin between 1 and 2, watchdog on engine completion.
module rtc_bus_scheduler #(
   parameter int TIMEOUT = 127,
   parameter int AW      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        req,
   input  logic [2:0]        req_wr,
   input  logic [3*AW-1:0]   req_addr,
   input  logic [23:0]       req_wdata,
   output logic [2:0]        gnt,
   output logic [2:0]        ack,
   output logic [7:0]        rdata,
   output logic              timeout_err,
   output logic              eng_start,
   output logic              eng_w_r,
   output logic [AW-1:0]     eng_addr,
   output logic [7:0]        eng_wdata,
   input  logic              eng_done,
   input  logic [7:0]        eng_rdata
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      START = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } state_t;

   // The counter reaches TIMEOUT on the edge leaving the last allowed WAIT cycle.
   localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

   state_t        state, state_nxt;
   logic [6:0]    cnt, cnt_nxt;
   logic          rr_fav2, rr_fav2_nxt;

   logic [2:0]    gnt_nxt;
   logic [2:0]    ack_nxt;
   logic [7:0]    rdata_nxt;
   logic          timeout_err_nxt;
   logic          eng_start_nxt;
   logic          eng_w_r_nxt;
   logic [AW-1:0] eng_addr_nxt;
   logic [7:0]    eng_wdata_nxt;

   logic [2:0]    win_oh;
   logic          win_wr;
   logic [AW-1:0] win_addr;
   logic [7:0]    win_wdata;

   // Winner selection: requester 0 always first; 1 and 2 share by last-served pointer.
   always_comb begin
      win_oh = 3'b000;
      if (req[0]) begin
         win_oh = 3'b001;
      end else if (req[1] && req[2]) begin
         win_oh = rr_fav2 ? 3'b100 : 3'b010;
      end else if (req[1]) begin
         win_oh = 3'b010;
      end else if (req[2]) begin
         win_oh = 3'b100;
      end
   end

   always_comb begin
      win_wr    = 1'b0;
      win_addr  = '0;
      win_wdata = 8'h00;
      case (win_oh)
         3'b001: begin
            win_wr    = req_wr[0];
            win_addr  = req_addr[0*AW +: AW];
            win_wdata = req_wdata[7:0];
         end
         3'b010: begin
            win_wr    = req_wr[1];
            win_addr  = req_addr[1*AW +: AW];
            win_wdata = req_wdata[15:8];
         end
         3'b100: begin
            win_wr    = req_wr[2];
            win_addr  = req_addr[2*AW +: AW];
            win_wdata = req_wdata[23:16];
         end
         default: begin
            win_wr    = 1'b0;
            win_addr  = '0;
            win_wdata = 8'h00;
         end
      endcase
   end

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      rr_fav2_nxt     = rr_fav2;
      gnt_nxt         = gnt;
      ack_nxt         = 3'b000;
      rdata_nxt       = 8'h00;
      timeout_err_nxt = 1'b0;
      eng_start_nxt   = 1'b0;
      eng_w_r_nxt     = eng_w_r;
      eng_addr_nxt    = eng_addr;
      eng_wdata_nxt   = eng_wdata;

      case (state)
         IDLE: begin
            gnt_nxt = 3'b000;
            if (|req) begin
               state_nxt     = GRANT;
               gnt_nxt       = win_oh;
               eng_w_r_nxt   = win_wr;
               eng_addr_nxt  = win_addr;
               eng_wdata_nxt = win_wdata;
               if (win_oh == 3'b010) begin
                  rr_fav2_nxt = 1'b1;
               end else if (win_oh == 3'b100) begin
                  rr_fav2_nxt = 1'b0;
               end
            end
         end
         GRANT: begin
            state_nxt     = START;
            eng_start_nxt = 1'b1;
         end
         START: begin
            state_nxt = WAIT;
            cnt_nxt   = 7'd0;
         end
         WAIT: begin
            cnt_nxt = cnt + 7'd1;
            // Completion beats the watchdog when both land on the same cycle.
            if (eng_done) begin
               state_nxt = DONE;
               ack_nxt   = gnt;
               rdata_nxt = eng_w_r ? 8'h00 : eng_rdata;
            end else if (cnt == CNT_LAST) begin
               state_nxt       = DONE;
               ack_nxt         = gnt;
               timeout_err_nxt = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            gnt_nxt   = 3'b000;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = 3'b000;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= 7'd0;
         rr_fav2     <= 1'b0;
         gnt         <= 3'b000;
         ack         <= 3'b000;
         rdata       <= 8'h00;
         timeout_err <= 1'b0;
         eng_start   <= 1'b0;
         eng_w_r     <= 1'b0;
         eng_addr    <= '0;
         eng_wdata   <= 8'h00;
      end else begin
         cnt         <= cnt_nxt;
         rr_fav2     <= rr_fav2_nxt;
         gnt         <= gnt_nxt;
         ack         <= ack_nxt;
         rdata       <= rdata_nxt;
         timeout_err <= timeout_err_nxt;
         eng_start   <= eng_start_nxt;
         eng_w_r     <= eng_w_r_nxt;
         eng_addr    <= eng_addr_nxt;
         eng_wdata   <= eng_wdata_nxt;
      end
   end

endmodule

// File: doc/rtc_bus_scheduler.md
RTC_BUS_SCHEDULER -- requirements
Module: rtc_bus_scheduler

Interface
REQ-001 Parameter: TIMEOUT, default 127, maximum number of WAIT cycles allowed for one RTC transaction before abort.
REQ-002 Parameter: AW, default 8, RTC register address width; data width is fixed at 8.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  3  level request per requester: bit0 init sequencer, bit1 user write path, bit2 periodic time read.
REQ-006 req_wr  input  3  per requester: 1 = write transaction, 0 = read transaction.
REQ-007 req_addr  input  3*AW  packed addresses; requester i occupies bits [i*AW +: AW].
REQ-008 req_wdata  input  24  packed write data; requester i occupies bits [i*8 +: 8].
REQ-009 gnt  output  3  one-hot grant, held for the whole transaction.
REQ-010 ack  output  3  one-cycle completion pulse to the granted requester.
REQ-011 rdata  output  8  read result, valid while ack is high.
REQ-012 timeout_err  output  1  one-cycle pulse coincident with an ack caused by timeout.
REQ-013 eng_start  output  1  one-cycle start pulse to the RTC bus transaction engine (drives a_d/cs/rd/wr).
REQ-014 eng_w_r  output  1  transaction type to the engine; 1 = write.
REQ-015 eng_addr  output  AW  register address to the engine.
REQ-016 eng_wdata  output  8  write data to the engine.
REQ-017 eng_done  input  1  one-cycle pulse from the engine: transaction finished.
REQ-018 eng_rdata  input  8  engine read data; valid with eng_done.

Function
REQ-019 The FSM SHALL have the states IDLE, GRANT, START, WAIT and DONE; all outputs are registered.
REQ-020 IDLE: if any req bit is high, the block SHALL select a winner, set gnt, latch that requester's wr/addr/wdata into the eng_* registers, and go to GRANT; otherwise it stays in IDLE.
REQ-021 Arbitration: req[0] SHALL have absolute priority; req[1] and req[2] SHALL alternate round-robin via a 1-bit last-served pointer, which updates only when one of them is granted.
REQ-022 GRANT SHALL last 1 cycle and then go to START; START SHALL assert eng_start for exactly 1 cycle and then go to WAIT.
REQ-023 WAIT: a 7-bit counter, cleared on entry, SHALL increment each cycle; on eng_done the FSM goes to DONE with rdata = eng_rdata (write: rdata = 8'h00).
REQ-024 WAIT: if the counter reaches TIMEOUT without eng_done, the FSM SHALL go to DONE with rdata = 8'h00 and timeout_err set for the DONE cycle.
REQ-025 If eng_done and the timeout coincide in the same cycle, eng_done SHALL win and timeout_err stays 0.
REQ-026 DONE SHALL last 1 cycle: ack[winner] = 1 and gnt is still held. On the next cycle gnt = 0 and the FSM returns to IDLE.
REQ-027 Latency: req sampled in IDLE at edge N gives gnt at N+1, eng_start at N+2, and ack one cycle after eng_done.
REQ-028 eng_addr, eng_wdata and eng_w_r SHALL be stable from GRANT through DONE; req changes after grant are ignored.
REQ-029 A req dropped before being sampled in IDLE is withdrawn and receives no ack.
REQ-030 A requester SHALL drop req by the cycle after ack; a req still high when IDLE samples it is treated as a new request.
REQ-031 eng_done pulses outside WAIT SHALL be ignored.
REQ-032 At most one gnt bit and at most one ack bit SHALL be high at any time.

Reset
REQ-033 While reset is asserted: state = IDLE, gnt = 0, ack = 0, rdata = 0, timeout_err = 0, eng_start = 0, eng_w_r = 0, eng_addr = 0, eng_wdata = 0, counter = 0, RR pointer = favour req[1].
REQ-034 Reset asserted mid-transaction SHALL abort it immediately, with no ack or timeout_err pulse issued.

Verification
REQ-035 Single read: req = 3'b100, addr 8'h21; engine returns eng_done with 8'h35 after 20 cycles -> gnt = 3'b100, one eng_start, eng_w_r = 0, ack = 3'b100 with rdata = 8'h35.
REQ-036 Priority: req = 3'b111 held -> grant order is req0, then req1, then req2, then req1 again (RR alternates once req0 is released).
REQ-037 Timeout: req[1] write to addr 8'h02, data 8'h10, eng_done never asserted -> ack = 3'b010 and timeout_err = 1 exactly TIMEOUT+1 cycles after eng_start, rdata = 8'h00.
REQ-038 Coincidence: eng_done arrives on the same cycle the counter hits TIMEOUT -> ack asserted, timeout_err = 0.
REQ-039 Reset mid-WAIT: assert reset 5 cycles after eng_start -> all outputs 0 at once, no ack; after release a pending req[0] is granted normally.
REQ-040 Stray eng_done while in IDLE -> no state change and no ack.
